// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//
// Services a cache miss by fetching one 16-byte block as WORDS sequential
// word reads. Each returned word is written into the data array; the tag
// array is written together with the last word. Request addresses are
// produced by an external combinational adder: this block drives the current
// request address on add_a and STRIDE on add_b, and takes add_sum as the
// next request address.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   miss_detected       cache miss, sampled only while idle
//   miss_address        byte address of the missing access
//   fsm_busy            high while a fill is in progress (pipeline stall)
//   mem_read_en         memory read request strobe, one word per cycle
//   memory_address      byte address of the current request
//   memory_data_valid   returned word is valid this cycle
//   write_data_array    data-array write enable
//   write_tag_array     tag-array write enable (with the last word)
//   block_base          miss_address with the low nibble cleared
//   word_index          data-array word index of the accepted response
//   add_a, add_b        address adder operands
//   add_sum, add_error  address adder result and overflow (overflow unused)
// ----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int          WORDS  = 8,
    parameter logic [15:0] STRIDE = 16'h0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    input  logic        memory_data_valid,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] block_base,
    output logic [2:0]  word_index,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_sum,
    input  logic        add_error
);

    typedef enum logic {IDLE, FILL} state_t;

    // Counters are one bit wider than word_index so they can reach WORDS.
    localparam logic [3:0] WORDS_C = 4'(WORDS);

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [3:0]  iss_cnt_q, iss_cnt_d;
    logic [3:0]  rcv_cnt_q, rcv_cnt_d;

    logic issuing;
    logic accept;
    logic last_word;

    // Adder overflow cannot matter: only WORDS requests are issued per block.
    logic unused_add_error;
    assign unused_add_error = add_error;

    assign issuing   = (state_q == FILL) && (iss_cnt_q < WORDS_C);
    // Only responses to requests issued on earlier cycles are accepted;
    // anything beyond the outstanding count is unsolicited and dropped.
    assign accept    = (state_q == FILL) && memory_data_valid && (rcv_cnt_q < iss_cnt_q);
    assign last_word = accept && (rcv_cnt_q == WORDS_C - 4'd1);

    assign fsm_busy         = (state_q == FILL);
    assign mem_read_en      = issuing;
    assign memory_address   = req_addr_q;
    assign write_data_array = accept;
    assign write_tag_array  = last_word;
    assign block_base       = base_q;
    assign word_index       = rcv_cnt_q[2:0];
    assign add_a            = req_addr_q;
    assign add_b            = STRIDE;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        req_addr_d = req_addr_q;
        iss_cnt_d  = iss_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d     = {miss_address[15:4], 4'h0};
                    req_addr_d = {miss_address[15:4], 4'h0};
                    iss_cnt_d  = 4'd0;
                    rcv_cnt_d  = 4'd0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (issuing) begin
                    req_addr_d = add_sum;
                    iss_cnt_d  = iss_cnt_q + 4'd1;
                end
                if (accept) begin
                    rcv_cnt_d = rcv_cnt_q + 4'd1;
                end
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= 16'h0000;
            req_addr_q <= 16'h0000;
            iss_cnt_q  <= 4'd0;
            rcv_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            req_addr_q <= req_addr_d;
            iss_cnt_q  <= iss_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] block_base;
    logic [2:0]  word_index;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_error;

    // External adder model; stride4 substitutes +4 to prove add_sum is consumed.
    logic        stride4;
    logic [16:0] full_sum;
    assign full_sum  = {1'b0, add_a} + {1'b0, (stride4 ? 16'h0004 : add_b)};
    assign add_sum   = full_sum[15:0];
    assign add_error = full_sum[16];

    int errors = 0;
    int checks = 0;

    logic [15:0] addr_q[$];
    int          idx_q[$];

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .block_base        (block_base),
        .word_index        (word_index),
        .add_a             (add_a),
        .add_b             (add_b),
        .add_sum           (add_sum),
        .add_error         (add_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one fill. vmode 0: each response 4 cycles after its request;
    // vmode 1: valid follows the repeating pattern 1,0,0,1,1,0,1.
    // chained: the miss is already high and the FSM enters FILL on the next edge.
    task automatic do_fill(input logic [15:0] miss, input int vmode, input bit hold,
                           input bit chained, input int stride);
        logic [15:0] base;
        logic [15:0] ea;
        logic [6:0]  pat;
        int          due[$];
        int          iss;
        int          rcv;
        int          ei;
        bit          done;
        bit          finished;
        bit          v;
        bit          exp_wr;
        pat      = 7'b1011001;
        base     = {miss[15:4], 4'h0};
        iss      = 0;
        rcv      = 0;
        done     = 0;
        finished = 0;
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(base + 16'(i * stride));
            idx_q.push_back(i);
        end
        if (!chained) begin
            @(negedge clk);
            miss_detected     = 1'b1;
            miss_address      = miss;
            memory_data_valid = 1'b0;
            #1;
            checks++;
            if (fsm_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy: got %b expected 0", fsm_busy);
            end
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) miss_detected = 1'b0;
            if (vmode == 0) begin
                v = (due.size() > 0 && due[0] == k);
                if (v) void'(due.pop_front());
            end else begin
                v = pat[k % 7];
            end
            memory_data_valid = v;
            #1;
            if (done) begin
                checks++;
                if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0) begin
                    errors++;
                    $display("FAIL after_tag: busy/rd/wr got %b%b%b expected 000",
                             fsm_busy, mem_read_en, write_data_array);
                end
                finished = 1;
                break;
            end
            if (k == 0) begin
                checks++;
                if (block_base !== base) begin
                    errors++;
                    $display("FAIL block_base: got %h expected %h", block_base, base);
                end
            end
            checks++;
            if (fsm_busy !== 1'b1) begin
                errors++;
                $display("FAIL fill_busy: cycle %0d got %b expected 1", k, fsm_busy);
            end
            checks++;
            if (add_a !== memory_address || add_b !== 16'h0002) begin
                errors++;
                $display("FAIL adder_ops: add_a %h add_b %h expected %h 0002",
                         add_a, add_b, memory_address);
            end
            exp_wr = v && (rcv < iss);
            checks++;
            if (mem_read_en !== (iss < 8)) begin
                errors++;
                $display("FAIL rd_en: cycle %0d got %b expected %b", k, mem_read_en, iss < 8);
            end
            if (mem_read_en === 1'b1) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_req: got %h expected none", memory_address);
                end else begin
                    ea = addr_q.pop_front();
                    checks++;
                    if (memory_address !== ea) begin
                        errors++;
                        $display("FAIL req_addr: got %h expected %h", memory_address, ea);
                    end
                end
                due.push_back(k + 4);
                iss++;
            end
            checks++;
            if (write_data_array !== exp_wr) begin
                errors++;
                $display("FAIL data_wr: cycle %0d got %b expected %b", k, write_data_array, exp_wr);
            end
            if (exp_wr) begin
                ei = (idx_q.size() > 0) ? idx_q.pop_front() : -1;
                checks++;
                if (int'(word_index) !== ei || write_tag_array !== (ei == 7)) begin
                    errors++;
                    $display("FAIL word_idx: idx %0d tag %b expected %0d %b",
                             word_index, write_tag_array, ei, ei == 7);
                end
                rcv++;
                if (rcv == 8) done = 1;
            end else begin
                checks++;
                if (write_tag_array !== 1'b0) begin
                    errors++;
                    $display("FAIL tag_wr: got %b expected 0", write_tag_array);
                end
            end
        end
        checks++;
        if (!finished || addr_q.size() != 0 || idx_q.size() != 0) begin
            errors++;
            $display("FAIL fill_end: finished %0d left reqs %0d left words %0d expected 1 0 0",
                     finished, addr_q.size(), idx_q.size());
        end
        addr_q.delete();
        idx_q.delete();
        memory_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        stride4           = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
            write_tag_array !== 1'b0 || memory_address !== 16'h0 || block_base !== 16'h0 ||
            word_index !== 3'd0 || add_a !== 16'h0 || add_b !== 16'h0002) begin
            errors++;
            $display("FAIL reset_state: busy %b rd %b wr %b tag %b addr %h base %h idx %0d a %h b %h",
                     fsm_busy, mem_read_en, write_data_array, write_tag_array,
                     memory_address, block_base, word_index, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fill();
        do_fill(16'h1234, 0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_wrap();
        do_fill(16'hFFFB, 0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_irregular();
        do_fill(16'h0A5C, 1, 1'b0, 1'b0, 2);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        memory_data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (write_data_array !== 1'b0 || fsm_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: wr %b busy %b expected 0 0", write_data_array, fsm_busy);
            end
            @(negedge clk);
        end
        memory_data_valid = 1'b0;
        do_fill(16'h2220, 0, 1'b1, 1'b0, 2);
        do_fill(16'h2220, 0, 1'b0, 1'b1, 2);
        @(negedge clk);
        memory_data_valid = 1'b1;
        #1;
        checks++;
        if (write_data_array !== 1'b0 || fsm_busy !== 1'b0) begin
            errors++;
            $display("FAIL ninth_valid: wr %b busy %b expected 0 0", write_data_array, fsm_busy);
        end
        @(negedge clk);
        memory_data_valid = 1'b0;
    endtask

    task automatic test_adder_stride();
        stride4 = 1'b1;
        do_fill(16'h1234, 0, 1'b0, 1'b0, 4);
        stride4 = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int due[$];
        int wr_seen;
        bit v;
        wr_seen = 0;
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h3370;
        for (int k = 0; k < 100 && wr_seen < 3; k++) begin
            @(negedge clk);
            miss_detected = 1'b0;
            v = (due.size() > 0 && due[0] == k);
            if (v) void'(due.pop_front());
            memory_data_valid = v;
            #1;
            if (mem_read_en === 1'b1) due.push_back(k + 4);
            if (write_data_array === 1'b1) wr_seen++;
        end
        checks++;
        if (wr_seen != 3) begin
            errors++;
            $display("FAIL mid_fill_progress: got %0d writes expected 3", wr_seen);
        end
        @(posedge clk);
        #1;
        memory_data_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
            write_tag_array !== 1'b0 || memory_address !== 16'h0 || block_base !== 16'h0 ||
            word_index !== 3'd0 || add_a !== 16'h0 || add_b !== 16'h0002) begin
            errors++;
            $display("FAIL async_reset: busy %b rd %b wr %b tag %b addr %h base %h idx %0d a %h b %h",
                     fsm_busy, mem_read_en, write_data_array, write_tag_array,
                     memory_address, block_base, word_index, add_a, add_b);
        end
        @(negedge clk);
        memory_data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fill(16'h0450, 0, 1'b0, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap();
        test_irregular();
        test_spurious();
        test_adder_stride();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Services a cache miss by fetching one 16-byte block as eight sequential 16-bit word reads from memory.
- Writes each returned word into the cache data array, then writes the tag array when the last word arrives.
- Sits directly upstream of the shared 16-bit carry-lookahead address adder.
  - It drives both adder operands every cycle.
  - It consumes the adder sum as its next memory request address.
- Stalls the pipeline via fsm_busy while a fill is in progress.

Parameters:
- WORDS, 8, words per cache block. The 3-bit word_index requires WORDS <= 8.
- STRIDE, 16'h0002, byte increment between consecutive word requests. Driven on add_b.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- miss_detected  input  1  cache miss, sampled only in IDLE.
- miss_address  input  16  byte address of the missing access.
- fsm_busy  output  1  high while a fill is in progress.
- mem_read_en  output  1  memory read request strobe, one word per cycle.
- memory_address  output  16  byte address of the current request.
- memory_data_valid  input  1  the returned word is valid this cycle.
- write_data_array  output  1  write-enable for the data array.
- write_tag_array  output  1  write-enable for the tag array.
- block_base  output  16  miss_address with bits [3:0] cleared, held for the whole fill.
- word_index  output  3  index of the word being written into the data array.
- add_a  output  16  adder operand A; carries the current request address.
- add_b  output  16  adder operand B; constant STRIDE.
- add_sum  input  16  adder result, combinational from add_a and add_b.
- add_error  input  1  adder overflow flag; ignored by this block.

Behaviour:
- Reset (asynchronous, rst_n = 0) applies the following immediately and regardless of state, including mid-fill:
  - State goes to IDLE; all counters and registers clear to 0.
  - fsm_busy, mem_read_en, write_data_array and write_tag_array are 0.
  - memory_address, block_base and word_index are 0.
  - add_a is 0; add_b is STRIDE.
- States: IDLE and FILL.
- IDLE:
  - When miss_detected = 1, on the next edge:
    - block_base <= {miss_address[15:4], 4'h0};
    - request address <= {miss_address[15:4], 4'h0};
    - issue counter <= 0 and receive counter <= 0;
    - state goes to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy = 1 combinationally for the whole state.
  - Request side:
    - While issue counter < WORDS: mem_read_en = 1 and memory_address = request address.
    - Each cycle, request address <= add_sum and the issue counter increments.
    - Requests go out on WORDS consecutive cycles (back-to-back, no bubbles), then mem_read_en = 0.
  - Adder interface:
    - add_a = request address in every state; add_b = STRIDE constant.
    - The adder is treated as purely combinational, so the sum is used in the same cycle.
    - add_error is ignored. Addresses never cross the block because only WORDS requests are issued; base 16'hFFF0 yields FFF0..FFFE.
  - Response side:
    - When memory_data_valid = 1 and receive counter < issue counter: write_data_array = 1 combinationally, word_index = receive counter, and the receive counter increments.
    - memory_data_valid with receive counter == issue counter (unsolicited) is ignored, with no write.
    - Requests and responses may overlap in the same cycle.
  - Completion:
    - On the accepted response with receive counter == WORDS-1: write_data_array = 1 and write_tag_array = 1 in the same cycle.
    - Next state is IDLE, and fsm_busy drops the following cycle.
  - miss_detected during FILL, including the completion cycle, is ignored.
    - A miss still asserted on the first IDLE cycle starts a new fill (one idle cycle minimum between fills).
- Memory latency is opaque; the FSM waits indefinitely for responses. It contains no timeout.

Test Plan:
- Reset mid-fill: assert rst_n = 0 after 3 words received -> outputs 0 asynchronously; after release, state is IDLE and the next miss starts a fresh fill at word 0.
- Basic fill: miss_address = 16'h1234, memory returns valid 4 cycles after each request -> memory_address 1230, 1232 … 123E on 8 consecutive mem_read_en cycles.
  - word_index 0..7 on the 8 write_data_array pulses.
  - write_tag_array asserted only with word 7.
  - fsm_busy high from the cycle after the miss until the cycle after the tag write.
- Address wrap boundary: miss_address = 16'hFFFB -> block_base = FFF0, requests FFF0..FFFE, exactly 8 requests, add_error ignored.
- Irregular returns: valid pattern with gaps (1,0,0,1,1,0,1,…) -> exactly 8 data writes with indices in order; completion waits for the 8th valid.
- Spurious and overlapping inputs:
  - valid in IDLE -> no write.
  - miss_detected held high through a fill -> ignored until IDLE, then a second fill starts on the first IDLE cycle.
  - a 9th unsolicited valid -> ignored.
- Adder hookup: check add_a equals memory_address and add_b = 0002 each FILL cycle; force add_sum = add_a + 4 -> requests stride by 4, confirming the block consumes the external sum.
